keypad_scanner: RTL

//  Scans a 4x4 hex matrix keypad and debounces it; inbound companion to the seven-segment driver.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/scan_tick.sv | 27 ++
 rtl/keypad_scanner.sv | 137 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDeb,
        StPress,
        StRel
    } state_e;

    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_BS    = 4'hB;
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Index of the lowest-numbered low row; 3 when none is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Index of the strobed (low) bit in a one-hot-low column pattern.
    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider producing a one-cycle scan enable every SCAN_DIV clocks.
module scan_tick #(
    parameter int unsigned SCAN_DIV = 200000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int unsigned W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with debounce, key reporting and a BCD entry register.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 200000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    input  logic        RE,
    output logic [31:0] DO,
    output logic [3:0]  KEY,
    output logic        VALID,
    output logic        OVR
);
    import keypad_pkg::*;

    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          tick;
    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    state_e        state_q;
    logic [3:0]    col_q;
    logic [1:0]    row_idx_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   do_q;
    logic [31:0]   do_next;
    logic [3:0]    key_q;
    logic [3:0]    key_code;
    logic          valid_q;
    logic          ovr_q;

    scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick (
        .CLK (CLK),
        .RST (RST),
        .tick(tick)
    );

    assign cnt_inc  = cnt_q + CNT_ONE;
    assign key_code = {row_idx_q, col_index(col_q)};

    always_comb begin
        do_next = do_q;
        if (key_code <= 4'd9) begin
            do_next = {do_q[27:0], key_code};
        end else if (key_code == KEY_CLR) begin
            do_next = '0;
        end else if (key_code == KEY_BS) begin
            do_next = {4'h0, do_q[31:4]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            state_q    <= StScan;
            col_q      <= COL_RESET;
            row_idx_q  <= '0;
            cnt_q      <= '0;
            do_q       <= '0;
            key_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;

            // A read acknowledges; a key accepted this same cycle overrides below.
            if (RE) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end

            unique case (state_q)
                StScan: begin
                    if (tick) begin
                        if (row_sync_q != 4'hF) begin
                            row_idx_q <= lowest_low(row_sync_q);
                            cnt_q     <= CNT_ONE;
                            state_q   <= (CNT_DONE == CNT_ONE) ? StPress : StDeb;
                        end else begin
                            col_q <= {col_q[2:0], col_q[3]};
                        end
                    end
                end
                StDeb: begin
                    if (tick) begin
                        if (!row_sync_q[row_idx_q]) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CNT_DONE) state_q <= StPress;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StScan;
                        end
                    end
                end
                StPress: begin
                    key_q   <= key_code;
                    valid_q <= 1'b1;
                    ovr_q   <= RE ? 1'b0 : (ovr_q | valid_q);
                    do_q    <= do_next;
                    cnt_q   <= '0;
                    state_q <= StRel;
                end
                StRel: begin
                    if (tick) begin
                        if (row_sync_q == 4'hF) begin
                            if (cnt_inc == CNT_DONE) begin
                                cnt_q   <= '0;
                                state_q <= StScan;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= StScan;
            endcase
        end
    end

    assign COL   = col_q;
    assign DO    = do_q;
    assign KEY   = key_q;
    assign VALID = valid_q;
    assign OVR   = ovr_q;

endmodule
